shooter_game_sequencer: RTL and testbench

Game-level controller for the 2D shooter. Consumes the decoded IR key levels (start/left/right/stop/shoot) and per-frame collision flags, and sequences game state. Owns player X motion and the player bullet lifecycle (fire, fly, expire, hit). Drives the position and win/lose inputs of the VGA wrapper, replacing ad-hoc processor updates. All position updates are paced by a one-cycle frame_tick.

---
 rtl/shooter_game_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_shooter_game_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shooter_game_sequencer.sv
// Game sequencer: key edges, player motion, bullet lifecycle, score and win/lose FSM.
// All outputs registered; frame actions land one cycle after frame_tick; no backpressure (inputs are levels).
module shooter_game_sequencer #(
  parameter logic [9:0] X_MIN       = 10'd11,
  parameter logic [9:0] X_MAX       = 10'd610,
  parameter logic [9:0] X_START     = 10'd320,
  parameter logic [8:0] PLAYER_Y    = 9'd450,
  parameter logic [9:0] MOVE_STEP   = 10'd2,
  parameter logic [8:0] BULLET_STEP = 9'd4,
  parameter logic [8:0] Y_TOP       = 9'd11,
  parameter logic [3:0] COOLDOWN    = 4'd8,
  parameter logic [3:0] WIN_HITS    = 4'd3
) (
  input  logic       master_clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       left,
  input  logic       right,
  input  logic       stop,
  input  logic       shoot,
  input  logic       hit_enemy,
  input  logic       hit_player,
  output logic [9:0] playerXPosition,
  output logic [8:0] playerYPosition,
  output logic [9:0] bulletXPosition,
  output logic [8:0] bulletYPosition,
  output logic       bullet_active,
  output logic [1:0] game_state,
  output logic [3:0] score,
  output logic       win,
  output logic       lose
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_STOP  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  state_t      state, state_nxt;
  dir_t        dir, dir_nxt;
  logic        start_q, start_qq, shoot_q, shoot_qq;
  logic        start_rise, shoot_rise;
  logic [9:0]  px, px_nxt, bx, bx_nxt;
  logic [8:0]  py, by, by_nxt;
  logic        bact, bact_nxt;
  logic [3:0]  score_q, score_nxt, cd, cd_nxt;
  logic        fp, fp_nxt;
  logic        hit, fire;
  logic [10:0] px_inc, px_floor;
  logic [9:0]  y_limit;

  // Rise is seen one cycle after the level change reaches the first register.
  assign start_rise = start_q & ~start_qq;
  assign shoot_rise = shoot_q & ~shoot_qq;

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    px_nxt    = px;
    bx_nxt    = bx;
    by_nxt    = by;
    bact_nxt  = bact;
    score_nxt = score_q;
    cd_nxt    = cd;
    fp_nxt    = fp;
    hit       = 1'b0;
    fire      = 1'b0;
    px_inc    = {1'b0, px} + {1'b0, MOVE_STEP};
    px_floor  = {1'b0, X_MIN} + {1'b0, MOVE_STEP};
    y_limit   = {1'b0, Y_TOP} + {1'b0, BULLET_STEP};

    case (state)
      ST_PLAY: begin
        hit  = hit_enemy & bact;
        // bact is the pre-tick value, so a bullet expiring this tick blocks a re-fire.
        fire = frame_tick & fp & ~bact & (cd == 4'd0);

        if (stop)       dir_nxt = DIR_STOP;
        else if (left)  dir_nxt = DIR_LEFT;
        else if (right) dir_nxt = DIR_RIGHT;

        if (hit) begin
          bact_nxt  = 1'b0;
          score_nxt = (score_q == 4'hF) ? score_q : score_q + 4'd1;
        end

        if (frame_tick) begin
          if (dir == DIR_LEFT)
            px_nxt = ({1'b0, px} < px_floor) ? X_MIN : px - MOVE_STEP;
          else if (dir == DIR_RIGHT)
            px_nxt = (px_inc > {1'b0, X_MAX}) ? X_MAX : px_inc[9:0];

          if (!hit && bact) begin
            if ({1'b0, by} < y_limit) bact_nxt = 1'b0;
            else                      by_nxt   = by - BULLET_STEP;
          end

          if (fire) begin
            bx_nxt   = px;
            by_nxt   = PLAYER_Y - 9'd10;
            bact_nxt = 1'b1;
            cd_nxt   = COOLDOWN;
          end else if (cd != 4'd0) begin
            cd_nxt = cd - 4'd1;
          end
        end

        fp_nxt = (fp & ~fire) | shoot_rise;

        if (hit_player)                            state_nxt = ST_LOSE;
        else if (hit && (score_nxt == WIN_HITS))   state_nxt = ST_WIN;

        if (state_nxt != ST_PLAY) fp_nxt = 1'b0;
      end

      default: begin
        if (start_rise) begin
          state_nxt = ST_PLAY;
          px_nxt    = X_START;
          score_nxt = 4'd0;
          bact_nxt  = 1'b0;
          cd_nxt    = 4'd0;
          dir_nxt   = DIR_STOP;
          fp_nxt    = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge master_clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      dir      <= DIR_STOP;
      start_q  <= 1'b0;
      start_qq <= 1'b0;
      shoot_q  <= 1'b0;
      shoot_qq <= 1'b0;
      px       <= X_START;
      py       <= PLAYER_Y;
      bx       <= 10'd0;
      by       <= 9'd0;
      bact     <= 1'b0;
      score_q  <= 4'd0;
      cd       <= 4'd0;
      fp       <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      start_q  <= start;
      start_qq <= start_q;
      shoot_q  <= shoot;
      shoot_qq <= shoot_q;
      px       <= px_nxt;
      py       <= PLAYER_Y;
      bx       <= bx_nxt;
      by       <= by_nxt;
      bact     <= bact_nxt;
      score_q  <= score_nxt;
      cd       <= cd_nxt;
      fp       <= fp_nxt;
    end
  end

  assign playerXPosition = px;
  assign playerYPosition = py;
  assign bulletXPosition = bx;
  assign bulletYPosition = by;
  assign bullet_active   = bact;
  assign game_state      = state;
  assign score           = score_q;
  assign win             = (state == ST_WIN);
  assign lose            = (state == ST_LOSE);

endmodule

// File: tb/tb_shooter_game_sequencer.sv
// Bench for shooter_game_sequencer: directed game scenarios then random play, against a rule-level model.
module tb_shooter_game_sequencer;

  logic       master_clk = 1'b0;
  logic       resetn;
  logic       frame_tick, start, left, right, stop, shoot, hit_enemy, hit_player;
  logic [9:0] playerXPosition, bulletXPosition;
  logic [8:0] playerYPosition, bulletYPosition;
  logic       bullet_active, win, lose;
  logic [1:0] game_state;
  logic [3:0] score;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int IDLE = 0, PLAY = 1, WON = 2, LOST = 3;
  localparam int GO_STOP = 0, GO_LEFT = 1, GO_RIGHT = 2;

  always #5 master_clk = ~master_clk;

  shooter_game_sequencer dut (
    .master_clk      (master_clk),
    .resetn          (resetn),
    .frame_tick      (frame_tick),
    .start           (start),
    .left            (left),
    .right           (right),
    .stop            (stop),
    .shoot           (shoot),
    .hit_enemy       (hit_enemy),
    .hit_player      (hit_player),
    .playerXPosition (playerXPosition),
    .playerYPosition (playerYPosition),
    .bulletXPosition (bulletXPosition),
    .bulletYPosition (bulletYPosition),
    .bullet_active   (bullet_active),
    .game_state      (game_state),
    .score           (score),
    .win             (win),
    .lose            (lose)
  );

  // Game model: the state of play after each clock, derived from the rules.
  int m_state, m_dir, m_px, m_bx, m_by, m_live, m_score, m_cool, m_pend;
  bit start_hist[2];
  bit shoot_hist[2];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_dir = GO_STOP; m_px = 320; m_bx = 0; m_by = 0;
    m_live = 0; m_score = 0; m_cool = 0; m_pend = 0;
    start_hist = '{0, 0};
    shoot_hist = '{0, 0};
  endtask

  // One clock edge with the inputs currently applied.
  task automatic model_clock();
    bit start_edge, shoot_edge, scored, launched;
    int nx_state, nx_dir, nx_px, nx_bx, nx_by, nx_live, nx_score, nx_cool, nx_pend;
    start_edge = start_hist[0] && !start_hist[1];
    shoot_edge = shoot_hist[0] && !shoot_hist[1];
    start_hist[1] = start_hist[0]; start_hist[0] = start;
    shoot_hist[1] = shoot_hist[0]; shoot_hist[0] = shoot;
    nx_state = m_state; nx_dir = m_dir; nx_px = m_px; nx_bx = m_bx; nx_by = m_by;
    nx_live = m_live; nx_score = m_score; nx_cool = m_cool; nx_pend = m_pend;
    if (m_state == PLAY) begin
      scored   = hit_enemy && (m_live != 0);
      launched = frame_tick && (m_pend != 0) && (m_live == 0) && (m_cool == 0);
      if (stop)       nx_dir = GO_STOP;
      else if (left)  nx_dir = GO_LEFT;
      else if (right) nx_dir = GO_RIGHT;
      if (scored) begin
        nx_live  = 0;
        nx_score = min_i(m_score + 1, 15);
      end
      if (frame_tick) begin
        if (m_dir == GO_LEFT)  nx_px = max_i(m_px - 2, 11);
        if (m_dir == GO_RIGHT) nx_px = min_i(m_px + 2, 610);
        if (!scored && m_live != 0) begin
          if (m_by < 15) nx_live = 0;
          else           nx_by   = m_by - 4;
        end
        if (launched) begin
          nx_bx = m_px; nx_by = 440; nx_live = 1; nx_cool = 8;
        end else if (m_cool > 0) begin
          nx_cool = m_cool - 1;
        end
      end
      nx_pend = ((m_pend != 0) && !launched) || shoot_edge;
      if (hit_player)                      nx_state = LOST;
      else if (scored && nx_score == 3)    nx_state = WON;
      if (nx_state != PLAY) nx_pend = 0;
    end else if (start_edge) begin
      nx_state = PLAY; nx_px = 320; nx_score = 0; nx_live = 0;
      nx_cool = 0; nx_dir = GO_STOP; nx_pend = 0;
    end
    m_state = nx_state; m_dir = nx_dir; m_px = nx_px; m_bx = nx_bx; m_by = nx_by;
    m_live = nx_live; m_score = nx_score; m_cool = nx_cool; m_pend = nx_pend;
  endtask

  task automatic compare_all();
    chk("player_x", int'(playerXPosition), m_px);
    chk("player_y", int'(playerYPosition), 450);
    chk("bullet_x", int'(bulletXPosition), m_bx);
    chk("bullet_y", int'(bulletYPosition), m_by);
    chk("bullet_active", int'(bullet_active), m_live);
    chk("game_state", int'(game_state), m_state);
    chk("score", int'(score), m_score);
    chk("win", int'(win), (m_state == WON) ? 1 : 0);
    chk("lose", int'(lose), (m_state == LOST) ? 1 : 0);
  endtask

  task automatic step();
    model_clock();
    @(posedge master_clk);
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic press_start();
    start = 1'b1; steps(3);
    start = 1'b0; steps(3);
  endtask

  task automatic press_shoot();
    shoot = 1'b1; steps(3);
    shoot = 1'b0; step();
  endtask

  task automatic hit_bullet();
    hit_enemy = 1'b1; steps(5);
    hit_enemy = 1'b0; step();
  endtask

  // Async reset asserted mid-cycle; outputs checked before any clock edge.
  task automatic pulse_reset();
    resetn = 1'b0;
    #2;
    model_reset();
    compare_all();
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    {frame_tick, start, left, right, stop, shoot, hit_enemy, hit_player} = '0;
    model_reset();
    #12;
    compare_all();
    chk("reset_x", int'(playerXPosition), 320);
    chk("reset_state", int'(game_state), 0);
    @(posedge master_clk); #1;
    resetn = 1'b1;
    steps(2);

    press_start();
    chk("start_state", int'(game_state), 1);
    chk("start_x", int'(playerXPosition), 320);
    chk("start_score", int'(score), 0);

    right = 1'b1; step();
    frames(10);
    chk("move_right", int'(playerXPosition), 340);
    right = 1'b0; left = 1'b1; step();
    frames(120);
    chk("move_left", int'(playerXPosition), 100);
    left = 1'b0; stop = 1'b1; step();
    stop = 1'b0; step();

    press_shoot();
    frames(1);
    chk("fire_active", int'(bullet_active), 1);
    chk("fire_x", int'(bulletXPosition), 100);
    chk("fire_y", int'(bulletYPosition), 440);
    frames(1);
    chk("fly_y", int'(bulletYPosition), 436);
    press_shoot();
    frames(106);
    chk("last_y", int'(bulletYPosition), 12);
    chk("last_active", int'(bullet_active), 1);
    frames(1);
    chk("expired", int'(bullet_active), 0);
    frames(1);
    chk("pending_fire", int'(bullet_active), 1);
    chk("pending_y", int'(bulletYPosition), 440);

    left = 1'b1; step();
    frames(200);
    chk("clamp_left", int'(playerXPosition), 11);
    left = 1'b0; step();

    for (int b = 0; b < 3; b++) begin
      press_shoot();
      frames(9);
      chk("shot_live", int'(bullet_active), 1);
      hit_bullet();
      chk("score_step", int'(score), b + 1);
    end
    chk("win_state", int'(game_state), 2);
    chk("win_flag", int'(win), 1);
    right = 1'b1; frames(5); right = 1'b0;
    chk("frozen_x", int'(playerXPosition), 11);

    press_start();
    press_shoot();
    frames(1);
    hit_player = 1'b1; hit_enemy = 1'b1; step();
    hit_player = 1'b0; hit_enemy = 1'b0; step();
    chk("lose_state", int'(game_state), 3);
    chk("lose_flag", int'(lose), 1);
    chk("lose_score", int'(score), 1);
    press_start();
    chk("restart_state", int'(game_state), 1);
    chk("restart_score", int'(score), 0);
    chk("restart_x", int'(playerXPosition), 320);

    for (int b = 0; b < 2; b++) begin
      press_shoot(); frames(9); hit_bullet();
    end
    press_shoot(); frames(9);
    chk("mid_active", int'(bullet_active), 1);
    chk("mid_score", int'(score), 2);
    pulse_reset();
    chk("rst_state", int'(game_state), 0);
    chk("rst_active", int'(bullet_active), 0);
    chk("rst_score", int'(score), 0);
    step();

    for (int c = 0; c < 4000; c++) begin
      frame_tick = ($urandom_range(3) == 0);
      if ($urandom_range(40) == 0) start = ~start;
      if ($urandom_range(12) == 0) shoot = ~shoot;
      if ($urandom_range(10) == 0) left  = ~left;
      if ($urandom_range(10) == 0) right = ~right;
      if ($urandom_range(25) == 0) stop  = ~stop;
      if ($urandom_range(6) == 0)  hit_enemy = ~hit_enemy;
      hit_player = ($urandom_range(299) == 0);
      if ($urandom_range(999) == 0) pulse_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
